jtag_axi_top: RTL and testbench



---
 rtl/jtag_axi_top.sv | 352 +++++++++++++++++++++++++++++++++++
 tb/tb_jtag_axi_top.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_axi_top.sv
// JTAG-to-AXI4-Lite bridge driving a one-register LED slave.
// FPGA top of the LED demo: host commands become AXI-Lite transactions.
module jtag_axi_bridge #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_we,
    input  logic          host_wr,
    input  logic          host_rd,
    input  logic [31:0]   host_cmd,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    output logic [AW-1:0] awaddr,
    output logic          awvalid,
    input  logic          awready,
    output logic [DW-1:0] wdata,
    output logic [DW/8-1:0] wstrb,
    output logic          wvalid,
    input  logic          wready,
    input  logic [1:0]    bresp,
    input  logic          bvalid,
    output logic          bready,
    output logic [AW-1:0] araddr,
    output logic          arvalid,
    input  logic          arready,
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    rresp,
    input  logic          rvalid,
    output logic          rready
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   cmd_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] data_reg;
    logic [DW-1:0] read_data_reg;
    logic [1:0]    resp_reg;
    logic          axi_write_req;
    logic          axi_read_req;
    logic          wr_req_d;
    logic          rd_req_d;
    logic          axi_write_done;
    logic          axi_read_done;
    logic          aw_done;
    logic          w_done;
    logic          rd_pending;
    logic          op_wr;
    logic          start_wr;
    logic          start_rd;
    logic          aw_hs;
    logic          w_hs;
    logic          unused_cmd;

    assign start_wr   = axi_write_req & ~wr_req_d;
    assign start_rd   = axi_read_req & ~rd_req_d;
    assign aw_hs      = awvalid & awready;
    assign w_hs       = wvalid & wready;
    assign awaddr     = addr_reg;
    assign araddr     = addr_reg;
    assign wdata      = data_reg;
    assign wstrb      = '1;
    assign unused_cmd = ^cmd_reg;

    // Host-visible command registers, loaded on a host update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_reg  <= '0;
            addr_reg <= '0;
            data_reg <= '0;
        end else if (host_we) begin
            cmd_reg  <= host_cmd;
            addr_reg <= host_addr;
            data_reg <= host_data;
        end
    end

    // Request flops self-clear; delayed copies give edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axi_write_req <= 1'b0;
            axi_read_req  <= 1'b0;
            wr_req_d      <= 1'b0;
            rd_req_d      <= 1'b0;
        end else begin
            axi_write_req <= host_we & host_wr;
            axi_read_req  <= host_we & host_rd;
            wr_req_d      <= axi_write_req;
            rd_req_d      <= axi_read_req;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Handshake tracking, pending read, captured response and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            rd_pending    <= 1'b0;
            op_wr         <= 1'b0;
            read_data_reg <= '0;
            resp_reg      <= 2'b00;
        end else begin
            if (state == IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (start_wr) begin
                    op_wr      <= 1'b1;
                    rd_pending <= rd_pending | start_rd;
                end else if (start_rd | rd_pending) begin
                    op_wr      <= 1'b0;
                    rd_pending <= 1'b0;
                end
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (state == WR_RESP && bvalid)
                resp_reg <= bresp;
            if (state == RD_DATA && rvalid) begin
                read_data_reg <= rdata;
                resp_reg      <= rresp;
            end
        end
    end

    // Next-state logic; new edges are only seen in IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_wr)
                    state_nxt = WR;
                else if (start_rd | rd_pending)
                    state_nxt = RD_ADDR;
            end
            WR: begin
                if ((aw_done | aw_hs) & (w_done | w_hs))
                    state_nxt = WR_RESP;
            end
            WR_RESP: if (bvalid)  state_nxt = DONE;
            RD_ADDR: if (arready) state_nxt = RD_DATA;
            RD_DATA: if (rvalid)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // AXI control outputs and done pulses decoded from state.
    always_comb begin
        awvalid        = (state == WR) & ~aw_done;
        wvalid         = (state == WR) & ~w_done;
        bready         = (state == WR_RESP);
        arvalid        = (state == RD_ADDR);
        rready         = (state == RD_DATA);
        axi_write_done = (state == DONE) & op_wr;
        axi_read_done  = (state == DONE) & ~op_wr;
    end
endmodule

module axi_led_slave #(
    parameter int          AW        = 32,
    parameter int          DW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = 32'h43C00000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] awaddr,
    input  logic          awvalid,
    output logic          awready,
    input  logic [DW-1:0] wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic          wvalid,
    output logic          wready,
    output logic [1:0]    bresp,
    output logic          bvalid,
    input  logic          bready,
    input  logic [AW-1:0] araddr,
    input  logic          arvalid,
    output logic          arready,
    output logic [DW-1:0] rdata,
    output logic [1:0]    rresp,
    output logic          rvalid,
    input  logic          rready,
    output logic [3:0]    led_reg
);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic wr_acc;
    logic wr_hit;
    logic rd_hit;
    logic unused_bits;

    assign wr_acc      = awvalid & awready & wvalid & wready;
    assign wr_hit      = (awaddr == BASE_ADDR);
    assign rd_hit      = (araddr == BASE_ADDR);
    assign unused_bits = ^{wdata[DW-1:4], wstrb[DW/8-1:1]};

    // Write channel: joint AW/W accept pulse, then hold BVALID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            led_reg <= 4'h0;
        end else begin
            awready <= awvalid & wvalid & ~awready & ~bvalid;
            wready  <= awvalid & wvalid & ~wready & ~bvalid;
            if (wr_acc) begin
                bvalid <= 1'b1;
                bresp  <= wr_hit ? OKAY : SLVERR;
                if (wr_hit && wstrb[0])
                    led_reg <= wdata[3:0];
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read channel: ARREADY pulse, then hold RVALID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= OKAY;
        end else begin
            arready <= arvalid & ~arready & ~rvalid;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= rd_hit ? {{(DW-4){1'b0}}, led_reg} : '0;
                rresp  <= rd_hit ? OKAY : SLVERR;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end
endmodule

module jtag_axi_top #(
    parameter int            AXI_ADDR_WIDTH = 32,
    parameter int            AXI_DATA_WIDTH = 32,
    parameter logic [31:0]   BASE_ADDR      = 32'h43C00000
) (
    input  logic       sys_clk,
    input  logic       sys_resetn,
    output logic [3:0] led_pins
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;

    logic [1:0]     rst_sync;
    logic           rst_n;
    logic [AW-1:0]  awaddr;
    logic           awvalid;
    logic           awready;
    logic [DW-1:0]  wdata;
    logic [DW/8-1:0] wstrb;
    logic           wvalid;
    logic           wready;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;
    logic [AW-1:0]  araddr;
    logic           arvalid;
    logic           arready;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rvalid;
    logic           rready;
    logic [3:0]     led_reg;

    // Reset asserts asynchronously, releases after two clocks.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) rst_sync <= 2'b00;
        else             rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n    = rst_sync[1];
    assign led_pins = led_reg;

    // Host port is tied off; the JTAG TAP writes bridge registers.
    jtag_axi_bridge #(.AW(AW), .DW(DW)) u_jtag_axi_bridge (
        .clk       (sys_clk),
        .rst_n     (rst_n),
        .host_we   (1'b0),
        .host_wr   (1'b0),
        .host_rd   (1'b0),
        .host_cmd  (32'd0),
        .host_addr ({AW{1'b0}}),
        .host_data ({DW{1'b0}}),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    axi_led_slave #(
        .AW(AW), .DW(DW), .BASE_ADDR(BASE_ADDR[AW-1:0])
    ) u_led_slave (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .led_reg (led_reg)
    );
endmodule

// File: tb/tb_jtag_axi_top.sv
// Directed self-checking bench for jtag_axi_top.
// Host commands are issued by writing the bridge registers directly.
module tb_jtag_axi_top;
    localparam logic [31:0] BASE = 32'h43C00000;

    logic       sys_clk = 1'b0;
    logic       sys_resetn = 1'b0;
    logic [3:0] led_pins;
    int         n_cmp = 0;
    int         n_err = 0;

    jtag_axi_top dut (
        .sys_clk    (sys_clk),
        .sys_resetn (sys_resetn),
        .led_pins   (led_pins)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit hit, got timeout, need finish");
        $fatal(1, "watchdog");
    end

    task automatic host_set(input logic wr, input logic rd,
                            input logic [31:0] addr,
                            input logic [31:0] data);
        @(negedge sys_clk);
        dut.u_jtag_axi_bridge.cmd_reg  = wr ? 32'd1 : 32'd2;
        dut.u_jtag_axi_bridge.addr_reg = addr;
        dut.u_jtag_axi_bridge.data_reg = data;
        if (wr) dut.u_jtag_axi_bridge.axi_write_req = 1'b1;
        if (rd) dut.u_jtag_axi_bridge.axi_read_req  = 1'b1;
    endtask

    task automatic wait_done(input bit is_wr, output int lat);
        logic d;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge sys_clk);
            #1;
            d = is_wr ? dut.u_jtag_axi_bridge.axi_write_done
                      : dut.u_jtag_axi_bridge.axi_read_done;
            if (d && lat == 0) lat = i;
        end
    endtask

    task automatic test_reset();
        sys_resetn = 1'b0;
        repeat (10) @(posedge sys_clk);
        #1;
        n_cmp++;
        if (led_pins !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_led: got %h need 0", led_pins);
        end
        n_cmp++;
        if (dut.u_jtag_axi_bridge.axi_write_done !== 1'b0 ||
            dut.u_jtag_axi_bridge.axi_read_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done: got pulse need none");
        end
        n_cmp++;
        if (dut.u_jtag_axi_bridge.state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d need 0",
                     dut.u_jtag_axi_bridge.state);
        end
        n_cmp++;
        if (dut.u_jtag_axi_bridge.read_data_reg !== 32'h0 ||
            dut.awvalid !== 1'b0 || dut.arvalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_regs: rdata %h awv %b arv %b need 0",
                     dut.u_jtag_axi_bridge.read_data_reg,
                     dut.awvalid, dut.arvalid);
        end
        @(negedge sys_clk);
        sys_resetn = 1'b1;
        repeat (3) @(posedge sys_clk);
    endtask

    task automatic test_pattern_sweep();
        logic [3:0] pats [10] = '{4'h0, 4'hF, 4'hA, 4'h5, 4'h1,
                                  4'h2, 4'h4, 4'h8, 4'hC, 4'h3};
        int lat;
        for (int k = 0; k < 10; k++) begin
            host_set(1'b1, 1'b0, BASE, {28'hABCDE00, pats[k]});
            wait_done(1'b1, lat);
            n_cmp++;
            if (lat < 1 || lat > 6) begin
                n_err++;
                $display("FAIL sweep_wr_lat[%0d]: got %0d need 1..6", k, lat);
            end
            n_cmp++;
            if (led_pins !== pats[k]) begin
                n_err++;
                $display("FAIL sweep_led[%0d]: got %h need %h",
                         k, led_pins, pats[k]);
            end
            n_cmp++;
            if (dut.u_jtag_axi_bridge.resp_reg !== 2'b00) begin
                n_err++;
                $display("FAIL sweep_bresp[%0d]: got %b need 00",
                         k, dut.u_jtag_axi_bridge.resp_reg);
            end
            host_set(1'b0, 1'b1, BASE, 32'h0);
            wait_done(1'b0, lat);
            n_cmp++;
            if (lat < 1 || lat > 6) begin
                n_err++;
                $display("FAIL sweep_rd_lat[%0d]: got %0d need 1..6", k, lat);
            end
            n_cmp++;
            if (dut.u_jtag_axi_bridge.read_data_reg !== {28'h0, pats[k]}) begin
                n_err++;
                $display("FAIL sweep_rdata[%0d]: got %h need %h", k,
                         dut.u_jtag_axi_bridge.read_data_reg, {28'h0, pats[k]});
            end
        end
    endtask

    task automatic test_unmapped_write();
        int lat;
        host_set(1'b1, 1'b0, BASE, 32'h3);
        wait_done(1'b1, lat);
        host_set(1'b1, 1'b0, BASE + 32'd4, 32'hDEADBEEF);
        wait_done(1'b1, lat);
        n_cmp++;
        if (lat < 1 || lat > 6) begin
            n_err++;
            $display("FAIL unmap_wr_done: got lat %0d need 1..6", lat);
        end
        n_cmp++;
        if (dut.u_jtag_axi_bridge.resp_reg !== 2'b10) begin
            n_err++;
            $display("FAIL unmap_wr_resp: got %b need 10",
                     dut.u_jtag_axi_bridge.resp_reg);
        end
        n_cmp++;
        if (led_pins !== 4'b0011) begin
            n_err++;
            $display("FAIL unmap_wr_led: got %h need 3", led_pins);
        end
    endtask

    task automatic test_unmapped_read();
        int lat;
        host_set(1'b0, 1'b1, BASE + 32'd4, 32'h0);
        wait_done(1'b0, lat);
        n_cmp++;
        if (lat < 1 || lat > 6) begin
            n_err++;
            $display("FAIL unmap_rd_done: got lat %0d need 1..6", lat);
        end
        n_cmp++;
        if (dut.u_jtag_axi_bridge.read_data_reg !== 32'h0) begin
            n_err++;
            $display("FAIL unmap_rd_data: got %h need 0",
                     dut.u_jtag_axi_bridge.read_data_reg);
        end
        n_cmp++;
        if (dut.u_jtag_axi_bridge.resp_reg !== 2'b10) begin
            n_err++;
            $display("FAIL unmap_rd_resp: got %b need 10",
                     dut.u_jtag_axi_bridge.resp_reg);
        end
    endtask

    task automatic test_held_req();
        int aw_cnt = 0;
        int dn_cnt = 0;
        int lat;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            dut.u_jtag_axi_bridge.addr_reg      = BASE;
            dut.u_jtag_axi_bridge.data_reg      = 32'h6;
            dut.u_jtag_axi_bridge.axi_write_req = 1'b1;
            @(posedge sys_clk);
            #1;
            if (dut.awvalid && dut.awready) aw_cnt++;
            if (dut.u_jtag_axi_bridge.axi_write_done) dn_cnt++;
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge sys_clk);
            #1;
            if (dut.awvalid && dut.awready) aw_cnt++;
            if (dut.u_jtag_axi_bridge.axi_write_done) dn_cnt++;
        end
        n_cmp++;
        if (aw_cnt != 1) begin
            n_err++;
            $display("FAIL held_aw_count: got %0d need 1", aw_cnt);
        end
        n_cmp++;
        if (dn_cnt != 1) begin
            n_err++;
            $display("FAIL held_done_count: got %0d need 1", dn_cnt);
        end
        n_cmp++;
        if (led_pins !== 4'h6) begin
            n_err++;
            $display("FAIL held_led: got %h need 6", led_pins);
        end
        host_set(1'b1, 1'b0, BASE, 32'h9);
        wait_done(1'b1, lat);
        n_cmp++;
        if (lat < 1 || lat > 6 || led_pins !== 4'h9) begin
            n_err++;
            $display("FAIL held_new_edge: got lat %0d led %h need 1..6 / 9",
                     lat, led_pins);
        end
    endtask

    task automatic test_simultaneous();
        int wcyc = 0;
        int rcyc = 0;
        int wcnt = 0;
        int rcnt = 0;
        logic [3:0] led_at_rd = 4'h0;
        host_set(1'b1, 1'b1, BASE, 32'hC);
        for (int i = 1; i <= 14; i++) begin
            @(posedge sys_clk);
            #1;
            if (dut.u_jtag_axi_bridge.axi_write_done) begin
                wcnt++;
                wcyc = i;
            end
            if (dut.u_jtag_axi_bridge.axi_read_done) begin
                rcnt++;
                rcyc = i;
                led_at_rd = led_pins;
            end
        end
        n_cmp++;
        if (wcnt != 1 || rcnt != 1) begin
            n_err++;
            $display("FAIL simul_counts: got wr %0d rd %0d need 1 1",
                     wcnt, rcnt);
        end
        n_cmp++;
        if (wcyc < 1 || wcyc > 6 || rcyc <= wcyc) begin
            n_err++;
            $display("FAIL simul_order: got wr@%0d rd@%0d need wr<=6, rd>wr",
                     wcyc, rcyc);
        end
        n_cmp++;
        if (dut.u_jtag_axi_bridge.read_data_reg !== 32'hC ||
            led_at_rd !== 4'hC) begin
            n_err++;
            $display("FAIL simul_rdata: got %h led %h need c c",
                     dut.u_jtag_axi_bridge.read_data_reg, led_at_rd);
        end
    endtask

    task automatic test_reset_abort();
        int dn_cnt = 0;
        host_set(1'b1, 1'b0, BASE, 32'h5);
        @(posedge sys_clk);
        #1;
        n_cmp++;
        if (dut.u_jtag_axi_bridge.state !== 3'd1) begin
            n_err++;
            $display("FAIL abort_in_wr: got state %0d need 1",
                     dut.u_jtag_axi_bridge.state);
        end
        @(negedge sys_clk);
        sys_resetn = 1'b0;
        #1;
        n_cmp++;
        if (led_pins !== 4'h0 || dut.awvalid !== 1'b0 ||
            dut.u_jtag_axi_bridge.state !== 3'd0) begin
            n_err++;
            $display("FAIL abort_reset_vals: got led %h awv %b st %0d need 0",
                     led_pins, dut.awvalid, dut.u_jtag_axi_bridge.state);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge sys_clk);
            #1;
            if (dut.u_jtag_axi_bridge.axi_write_done ||
                dut.u_jtag_axi_bridge.axi_read_done) dn_cnt++;
        end
        @(negedge sys_clk);
        sys_resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge sys_clk);
            #1;
            if (dut.u_jtag_axi_bridge.axi_write_done ||
                dut.u_jtag_axi_bridge.axi_read_done) dn_cnt++;
        end
        n_cmp++;
        if (dn_cnt != 0) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d pulses need 0", dn_cnt);
        end
        n_cmp++;
        if (led_pins !== 4'h0) begin
            n_err++;
            $display("FAIL abort_led_after: got %h need 0", led_pins);
        end
    endtask

    initial begin
        test_reset();
        test_pattern_sweep();
        test_unmapped_write();
        test_unmapped_read();
        test_held_req();
        test_simultaneous();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
